gpu_text_accel: RTL and testbench
=================================

// Module: gpu_text_accel
// PURPOSE
//   Hardware clear/scroll/fill engine and CPU write port for the text-mode character buffer.
//   Sits between gpu register logic and the character_buffer write port, in the CPU clock domain.
//   Scrolling uses the circular top_line offset, so no rows are copied; only exposed rows are filled.
//   Translates CPU logical (row,col) writes to physical addresses. Cells carry a per-cell attribute.
// PARAMETERS
//   MAX_COLS   80     physical columns per row; 40-col mode uses MAX_COLS/2 active columns
//   ROWS       30     rows in buffer and on screen (top_line wraps modulo ROWS)
//   ATTR_W     6      per-cell attribute bits ({fg[2:0],bg[2:0]} at default)
//   FILL_CHAR  8'h20  character written by all fill operations
//   localparam COL_W=$clog2(MAX_COLS), ROW_W=$clog2(ROWS), ADDR_W=$clog2(MAX_COLS*ROWS), DW=8+ATTR_W
// PORTS
//   clk         in   1       single clock (CPU domain)
//   rst_n       in   1       synchronous active-low reset
//   mode_80col  in   1       1: active cols=MAX_COLS, 0: MAX_COLS/2
//   cmd_valid   in   1       command request
//   cmd_ready   out  1       = (state==IDLE) && !cpu_we
//   cmd_op      in   2       0 CLEAR, 1 SCROLL_UP, 2 SCROLL_DOWN, 3 CLEAR_EOL
//   cmd_n       in   ROW_W+1 line count for scrolls; row for CLEAR_EOL
//   cmd_col     in   COL_W   start column for CLEAR_EOL
//   fill_attr   in   ATTR_W  attribute for filled cells, sampled at cmd accept
//   cpu_we      in   1       CPU character write strobe
//   cpu_row     in   ROW_W   logical row
//   cpu_col     in   COL_W   logical column
//   cpu_data    in   8       character code
//   cpu_attr    in   ATTR_W  attribute for CPU write
//   busy        out  1       = state!=IDLE
//   done        out  1       one-cycle pulse when command completes
//   wr_dropped  out  1       one-cycle pulse when a CPU write is rejected
//   top_line    out  ROW_W   physical row shown at screen row 0
//   buf_we      out  1       registered write strobe to character buffer
//   buf_addr    out  ADDR_W  physical address = phys_row*MAX_COLS + col
//   buf_wdata   out  DW      {attr, char}
// BEHAVIOUR
//   Reset: state IDLE, top_line=0, buf_we=0, buf_addr=0, buf_wdata=0, done=0, wr_dropped=0.
//   Reset mid-command aborts it; no buf_we in the cycle after reset deasserts; top_line=0.
//   phys_row = (top_line + logical_row) mod ROWS, computed without overflow (ROW_W+1 bits).
//   CPU write, IDLE: cycle N cpu_we -> N+1 buf_we=1, translated addr, {cpu_attr,cpu_data}.
//   CPU write rejected if busy, cpu_row>=ROWS, or cpu_col>=active cols; wr_dropped pulses N+1.
//   Same cycle cpu_we and cmd_valid: CPU write wins; cmd_ready=0, so the command waits.
//   FSM IDLE -> FILL -> FINISH -> IDLE. Accept on cmd_valid&&cmd_ready.
//   FILL: one buf_we per cycle, walking rows ascending then cols ascending, data {fill_attr,FILL_CHAR}.
//   FINISH: one cycle, done=1, no write. First write is the cycle after accept.
//   CLEAR: all ROWS x MAX_COLS cells, including inactive columns; top_line unchanged.
//   SCROLL_UP n: at accept+1, top_line=(top_line+n) mod ROWS; fill logical rows ROWS-n..ROWS-1.
//   SCROLL_DOWN n: top_line=(top_line-n) mod ROWS; fill logical rows 0..n-1.
//   Scroll fills cover MAX_COLS columns per row; row translation uses the updated top_line.
//   n==0: no writes, FILL skipped, done at accept+1. n>=ROWS: top_line=0, then behaves as CLEAR.
//   CLEAR_EOL: fills logical row cmd_n, cols cmd_col..activecols-1.
//     If cmd_n>=ROWS or cmd_col>=active cols: no writes, done at accept+1.
//   Write count: CLEAR=ROWS*MAX_COLS; scroll=n*MAX_COLS; done at accept + writes + 1.
//   mode_80col changes mid-command do not affect the command; active cols are sampled at accept.
// TESTING
//   Reset then CLEAR, ROWS=30, MAX_COLS=80 -> 2400 writes, addr 0..2399 in order, all 0x20; done at accept+2401.
//   top_line=0, SCROLL_UP n=1 -> top_line=1; 80 writes, addr 0..79 (logical row 29 = phys 0); done at accept+81.
//   top_line=0, SCROLL_DOWN n=2 -> top_line=28; writes addr 2240..2399.
//   top_line=29, cpu_we row 3 col 5 data 0x41 -> next cycle buf_addr=2*80+5=165, wdata low byte 0x41.
//   40-col mode, cpu_col=40 -> no buf_we, wr_dropped pulse. cpu_we while busy -> dropped.
//   cpu_we and cmd_valid asserted together -> CPU write first; cmd accepted next cycle.
//   Reset asserted mid-CLEAR -> no further writes; top_line=0.

Source files
------------

// File: rtl/gpu_text_accel.sv
`default_nettype none
// ============================================================================
// Module   : gpu_text_accel
// Purpose  : Clear/scroll/fill engine and CPU write port for the text-mode
//            character buffer. Scrolling moves the circular top_line offset
//            instead of copying rows; only the rows exposed by a scroll are
//            refilled. CPU (row,col) writes are translated to physical
//            buffer addresses through top_line.
// Ports    : clk_i, rst_n_i        clock, synchronous active-low reset
//            mode_80col_i          1: MAX_COLS active columns, 0: MAX_COLS/2
//            cmd_valid_i/ready_o   command handshake (op, n, col, fill_attr)
//            cpu_we_i ...          CPU character write (row, col, data, attr)
//            busy_o, done_o        engine status / completion pulse
//            wr_dropped_o          pulse when a CPU write is rejected
//            top_line_o            physical row displayed at screen row 0
//            buf_we_o/addr_o/wdata_o  registered character buffer write port
// Revision : 1.0 - initial release
// ============================================================================
module gpu_text_accel #(
  parameter int          MAX_COLS  = 80,
  parameter int          ROWS      = 30,
  parameter int          ATTR_W    = 6,
  parameter logic [7:0]  FILL_CHAR = 8'h20,
  localparam int         COL_W     = $clog2(MAX_COLS),
  localparam int         ROW_W     = $clog2(ROWS),
  localparam int         ADDR_W    = $clog2(MAX_COLS * ROWS),
  localparam int         DW        = 8 + ATTR_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              mode_80col_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [ROW_W:0]    cmd_n_i,
  input  logic [COL_W-1:0]  cmd_col_i,
  input  logic [ATTR_W-1:0] fill_attr_i,
  input  logic              cpu_we_i,
  input  logic [ROW_W-1:0]  cpu_row_i,
  input  logic [COL_W-1:0]  cpu_col_i,
  input  logic [7:0]        cpu_data_i,
  input  logic [ATTR_W-1:0] cpu_attr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              wr_dropped_o,
  output logic [ROW_W-1:0]  top_line_o,
  output logic              buf_we_o,
  output logic [ADDR_W-1:0] buf_addr_o,
  output logic [DW-1:0]     buf_wdata_o
);

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_FILL   = 2'd1;
  localparam logic [1:0] c_ST_FINISH = 2'd2;

  localparam logic [1:0] c_OP_CLEAR  = 2'd0;
  localparam logic [1:0] c_OP_UP     = 2'd1;
  localparam logic [1:0] c_OP_DOWN   = 2'd2;
  localparam logic [1:0] c_OP_EOL    = 2'd3;

  localparam logic [ROW_W:0]   c_ROWS_N     = (ROW_W + 1)'(ROWS);
  localparam logic [ROW_W-1:0] c_LAST_ROW   = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] c_LAST_COL   = COL_W'(MAX_COLS - 1);
  localparam logic [COL_W:0]   c_COLS_FULL  = (COL_W + 1)'(MAX_COLS);
  localparam logic [COL_W:0]   c_COLS_HALF  = (COL_W + 1)'(MAX_COLS / 2);

  logic [1:0]        state_q, state_d;
  logic [ROW_W-1:0]  top_line_q;
  logic [ROW_W-1:0]  row_q, row_end_q;
  logic [COL_W-1:0]  col_q, col_end_q;
  logic [ATTR_W-1:0] attr_q;
  logic              buf_we_q, wr_dropped_q;
  logic [ADDR_W-1:0] buf_addr_q;
  logic [DW-1:0]     buf_wdata_q;

  logic              accept;
  logic              skip;
  logic              cpu_ok;
  logic              last_cell;
  logic [COL_W:0]    active_cols;
  logic [ROW_W:0]    up_sum;
  logic [ROW_W-1:0]  top_new;
  logic [ROW_W-1:0]  start_row, end_row, next_row;
  logic [COL_W-1:0]  start_col, end_col, next_col;

  // Logical row -> physical address. top and row are both below ROWS, so the
  // sum fits in ROW_W+1 bits and one conditional subtract is a full modulo.
  function automatic logic [ADDR_W-1:0] f_addr(input logic [ROW_W-1:0] top,
                                               input logic [ROW_W-1:0] row,
                                               input logic [COL_W-1:0] col);
    logic [ROW_W:0] sum;
    sum = {1'b0, top} + {1'b0, row};
    if (sum >= c_ROWS_N) sum = sum - c_ROWS_N;
    return ADDR_W'(ADDR_W'(sum) * ADDR_W'(MAX_COLS) + ADDR_W'(col));
  endfunction

  assign active_cols = mode_80col_i ? c_COLS_FULL : c_COLS_HALF;
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign cpu_ok      = ({1'b0, cpu_row_i} < c_ROWS_N) && ({1'b0, cpu_col_i} < active_cols);

  // Command decode: new top_line and the logical fill rectangle.
  always_comb begin
    top_new   = top_line_q;
    skip      = 1'b0;
    start_row = '0;
    end_row   = c_LAST_ROW;
    start_col = '0;
    end_col   = c_LAST_COL;
    up_sum    = {1'b0, top_line_q} + cmd_n_i;
    case (cmd_op_i)
      c_OP_UP: begin
        if (cmd_n_i == '0) begin
          skip = 1'b1;
        end else if (cmd_n_i >= c_ROWS_N) begin
          top_new = '0;
        end else begin
          top_new   = ROW_W'((up_sum >= c_ROWS_N) ? (up_sum - c_ROWS_N) : up_sum);
          start_row = ROW_W'(c_ROWS_N - cmd_n_i);
        end
      end
      c_OP_DOWN: begin
        if (cmd_n_i == '0) begin
          skip = 1'b1;
        end else if (cmd_n_i >= c_ROWS_N) begin
          top_new = '0;
        end else begin
          top_new = ROW_W'(({1'b0, top_line_q} >= cmd_n_i)
                           ? ({1'b0, top_line_q} - cmd_n_i)
                           : ({1'b0, top_line_q} + c_ROWS_N - cmd_n_i));
          end_row = ROW_W'(cmd_n_i - 1'b1);
        end
      end
      c_OP_EOL: begin
        if ((cmd_n_i >= c_ROWS_N) || ({1'b0, cmd_col_i} >= active_cols)) begin
          skip = 1'b1;
        end else begin
          start_row = cmd_n_i[ROW_W-1:0];
          end_row   = cmd_n_i[ROW_W-1:0];
          start_col = cmd_col_i;
          end_col   = COL_W'(active_cols - 1'b1);
        end
      end
      default: ; // c_OP_CLEAR: full buffer, top_line kept
    endcase
  end

  // Fill walker: cols ascending within a row, then next row from col 0.
  // Only multi-row fills ever wrap, and those always start at col 0.
  always_comb begin
    last_cell = (row_q == row_end_q) && (col_q == col_end_q);
    if (col_q == col_end_q) begin
      next_col = '0;
      next_row = row_q + ROW_W'(1);
    end else begin
      next_col = col_q + COL_W'(1);
      next_row = row_q;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= c_ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE:   if (accept) state_d = skip ? c_ST_FINISH : c_ST_FILL;
      c_ST_FILL:   if (last_cell) state_d = c_ST_FINISH;
      c_ST_FINISH: state_d = c_ST_IDLE;
      default:     state_d = c_ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    cmd_ready_o = (state_q == c_ST_IDLE) && !cpu_we_i;
    busy_o      = (state_q != c_ST_IDLE);
    done_o      = (state_q == c_ST_FINISH);
  end

  // Datapath: the buffer port is registered, so the first fill cell is
  // loaded at accept and each FILL cycle presents the cell currently in
  // row_q/col_q while loading the following one.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      top_line_q   <= '0;
      row_q        <= '0;
      col_q        <= '0;
      row_end_q    <= '0;
      col_end_q    <= '0;
      attr_q       <= '0;
      buf_we_q     <= 1'b0;
      wr_dropped_q <= 1'b0;
      buf_addr_q   <= '0;
      buf_wdata_q  <= '0;
    end else begin
      buf_we_q     <= 1'b0;
      wr_dropped_q <= cpu_we_i && (state_q != c_ST_IDLE);
      case (state_q)
        c_ST_IDLE: begin
          if (cpu_we_i) begin
            if (cpu_ok) begin
              buf_we_q    <= 1'b1;
              buf_addr_q  <= f_addr(top_line_q, cpu_row_i, cpu_col_i);
              buf_wdata_q <= {cpu_attr_i, cpu_data_i};
            end else begin
              wr_dropped_q <= 1'b1;
            end
          end else if (accept) begin
            top_line_q <= top_new;
            row_end_q  <= end_row;
            col_end_q  <= end_col;
            attr_q     <= fill_attr_i;
            row_q      <= start_row;
            col_q      <= start_col;
            if (!skip) begin
              buf_we_q    <= 1'b1;
              buf_addr_q  <= f_addr(top_new, start_row, start_col);
              buf_wdata_q <= {fill_attr_i, FILL_CHAR};
            end
          end
        end
        c_ST_FILL: begin
          if (!last_cell) begin
            row_q       <= next_row;
            col_q       <= next_col;
            buf_we_q    <= 1'b1;
            buf_addr_q  <= f_addr(top_line_q, next_row, next_col);
            buf_wdata_q <= {attr_q, FILL_CHAR};
          end
        end
        default: ;
      endcase
    end
  end

  assign top_line_o   = top_line_q;
  assign buf_we_o     = buf_we_q;
  assign buf_addr_o   = buf_addr_q;
  assign buf_wdata_o  = buf_wdata_q;
  assign wr_dropped_o = wr_dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_gpu_text_accel.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpu_text_accel
// Purpose  : Directed self-checking bench for gpu_text_accel (80x30 buffer).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpu_text_accel;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode_80col;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_n;
  logic [6:0]  cmd_col;
  logic [5:0]  fill_attr;
  logic        cpu_we;
  logic [4:0]  cpu_row;
  logic [6:0]  cpu_col;
  logic [7:0]  cpu_data;
  logic [5:0]  cpu_attr;
  logic        busy, done, wr_dropped, buf_we;
  logic [4:0]  top_line;
  logic [11:0] buf_addr;
  logic [13:0] buf_wdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  gpu_text_accel dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .mode_80col_i (mode_80col),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_op_i     (cmd_op),
    .cmd_n_i      (cmd_n),
    .cmd_col_i    (cmd_col),
    .fill_attr_i  (fill_attr),
    .cpu_we_i     (cpu_we),
    .cpu_row_i    (cpu_row),
    .cpu_col_i    (cpu_col),
    .cpu_data_i   (cpu_data),
    .cpu_attr_i   (cpu_attr),
    .busy_o       (busy),
    .done_o       (done),
    .wr_dropped_o (wr_dropped),
    .top_line_o   (top_line),
    .buf_we_o     (buf_we),
    .buf_addr_o   (buf_addr),
    .buf_wdata_o  (buf_wdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and follow it to done. Writes are expected to form a
  // contiguous address run starting at exp_first, all {attr, 0x20}.
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [5:0] n,
                         input logic [6:0] col, input logic [5:0] attr, input bit flip,
                         input int exp_writes, input int exp_first, input logic [4:0] exp_top);
    int cyc, nw, bad, done_cyc;
    cmd_op    = op;
    cmd_n     = n;
    cmd_col   = col;
    fill_attr = attr;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    if (flip) mode_80col = ~mode_80col;
    check({tag, "_top"}, 32'(top_line), 32'(exp_top));
    cyc = 1; nw = 0; bad = 0; done_cyc = -1;
    while (cyc <= 3000) begin
      if (buf_we) begin
        if (int'(buf_addr) != exp_first + nw || buf_wdata != {attr, 8'h20}) bad++;
        nw++;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      step();
      cyc++;
    end
    check({tag, "_writes"}, 32'(nw), 32'(exp_writes));
    check({tag, "_bad_cells"}, 32'(bad), 32'd0);
    check({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_writes + 1));
    step();
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic cpu_write(input logic [4:0] r, input logic [6:0] c,
                           input logic [7:0] d, input logic [5:0] a);
    cpu_row = r; cpu_col = c; cpu_data = d; cpu_attr = a;
    cpu_we  = 1'b1;
    step();
    cpu_we  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; mode_80col = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0;
    cmd_n = '0; cmd_col = '0; fill_attr = '0; cpu_we = 1'b0;
    cpu_row = '0; cpu_col = '0; cpu_data = '0; cpu_attr = '0;
    repeat (3) step();
    check("rst_busy",  {31'd0, busy},       32'd0);
    check("rst_done",  {31'd0, done},       32'd0);
    check("rst_drop",  {31'd0, wr_dropped}, 32'd0);
    check("rst_we",    {31'd0, buf_we},     32'd0);
    check("rst_addr",  32'(buf_addr),       32'd0);
    check("rst_wdata", 32'(buf_wdata),      32'd0);
    check("rst_top",   32'(top_line),       32'd0);
    check("rst_ready", {31'd0, cmd_ready},  32'd1);
    rst_n = 1'b1;
    step();

    run_cmd("clear",    2'd0, 6'd0, 7'd0, 6'h05, 1'b0, 2400, 0,    5'd0);
    run_cmd("up1",      2'd1, 6'd1, 7'd0, 6'h11, 1'b0, 80,   0,    5'd1);
    run_cmd("down1",    2'd2, 6'd1, 7'd0, 6'h22, 1'b0, 80,   0,    5'd0);
    run_cmd("down2",    2'd2, 6'd2, 7'd0, 6'h07, 1'b0, 160,  2240, 5'd28);
    run_cmd("up1_t28",  2'd1, 6'd1, 7'd0, 6'h38, 1'b0, 80,   2240, 5'd29);

    // top_line=29: logical row 3 is physical row 2
    cpu_write(5'd3, 7'd5, 8'h41, 6'h2A);
    check("cpu_we",    {31'd0, buf_we},     32'd1);
    check("cpu_addr",  32'(buf_addr),       32'd165);
    check("cpu_wdata", 32'(buf_wdata),      32'({6'h2A, 8'h41}));
    check("cpu_nodrop",{31'd0, wr_dropped}, 32'd0);

    mode_80col = 1'b0;
    cpu_write(5'd0, 7'd40, 8'h42, 6'h01);
    check("col40_we",   {31'd0, buf_we},     32'd0);
    check("col40_drop", {31'd0, wr_dropped}, 32'd1);
    cpu_write(5'd0, 7'd39, 8'h43, 6'h02);
    check("col39_we",   {31'd0, buf_we},     32'd1);
    check("col39_addr", 32'(buf_addr),       32'd2359);
    mode_80col = 1'b1;
    cpu_write(5'd30, 7'd0, 8'h44, 6'h03);
    check("row30_we",   {31'd0, buf_we},     32'd0);
    check("row30_drop", {31'd0, wr_dropped}, 32'd1);

    run_cmd("up0",       2'd1, 6'd0,  7'd0,  6'h01, 1'b0, 0, 0, 5'd29);
    mode_80col = 1'b0;
    run_cmd("eol_bad",   2'd3, 6'd1,  7'd40, 6'h01, 1'b0, 0, 0, 5'd29);
    run_cmd("eol_40",    2'd3, 6'd1,  7'd38, 6'h09, 1'b0, 2, 38, 5'd29);
    run_cmd("eol_row30", 2'd3, 6'd30, 7'd0,  6'h01, 1'b0, 0, 0, 5'd29);
    mode_80col = 1'b1;
    run_cmd("eol_flip",  2'd3, 6'd0,  7'd70, 6'h0C, 1'b1, 10, 2390, 5'd29);
    mode_80col = 1'b1;

    // CPU write during a CLEAR is dropped; reset mid-CLEAR aborts it
    cmd_op = 2'd0; fill_attr = 6'h00; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    repeat (4) step();
    cpu_write(5'd0, 7'd0, 8'h45, 6'h00);
    check("busy_drop",  {31'd0, wr_dropped}, 32'd1);
    check("busy_fill",  {31'd0, buf_we},     32'd1);
    repeat (3) step();
    rst_n = 1'b0;
    step();
    check("midrst_we",   {31'd0, buf_we}, 32'd0);
    check("midrst_busy", {31'd0, busy},   32'd0);
    check("midrst_top",  32'(top_line),   32'd0);
    rst_n = 1'b1;
    step();
    check("postrst_we",   {31'd0, buf_we}, 32'd0);
    check("postrst_busy", {31'd0, busy},   32'd0);

    // CPU write and command in the same cycle: write first, command next
    cmd_op = 2'd3; cmd_n = 6'd2; cmd_col = 7'd78; fill_attr = 6'h15; cmd_valid = 1'b1;
    cpu_row = 5'd0; cpu_col = 7'd0; cpu_data = 8'h55; cpu_attr = 6'h3F; cpu_we = 1'b1;
    step();
    cpu_we = 1'b0;
    check("same_we",    {31'd0, buf_we},  32'd1);
    check("same_addr",  32'(buf_addr),    32'd0);
    check("same_wdata", 32'(buf_wdata),   32'({6'h3F, 8'h55}));
    check("same_busy",  {31'd0, busy},    32'd0);
    run_cmd("same_eol", 2'd3, 6'd2, 7'd78, 6'h15, 1'b0, 2, 238, 5'd0);

    run_cmd("up3",    2'd1, 6'd3,  7'd0, 6'h0A, 1'b0, 240,  0, 5'd3);
    run_cmd("down31", 2'd2, 6'd31, 7'd0, 6'h0B, 1'b0, 2400, 0, 5'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
